// File: rtl/seq_controller.sv
// One-hot phase sequencer: IDLE -> RUN (phases 1..NUM_PHASES-1, dwell cycles each) -> EN -> VALID.
// Optional macro SEQ_CONTROLLER_LOOP_EN adds a 'loop' input that restarts RUN straight from VALID.
module seq_controller #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned DWELL_W    = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
`ifdef SEQ_CONTROLLER_LOOP_EN
    input  logic                  loop,
`endif
    input  logic [DWELL_W-1:0]    dwell,
    output logic [NUM_PHASES-1:0] phase,
    output logic                  en,
    output logic                  valid,
    output logic                  busy
);

    localparam int unsigned KW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
    localparam logic [KW-1:0] LastK = KW'(NUM_PHASES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StEn, StValid} state_e;

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_eff;
    logic               loop_req;
    logic               k_invalid;

`ifdef SEQ_CONTROLLER_LOOP_EN
    assign loop_req = loop;
`else
    assign loop_req = 1'b0;
`endif

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign k_invalid = (k_q == '0) || (32'(k_q) >= NUM_PHASES);

    // cnt holds the number of cycles still to go in the current phase, minus one
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StRun;
                    k_d     = KW'(1);
                    dwell_d = dwell_eff;
                    cnt_d   = dwell_eff - DWELL_W'(1);
                end
            end
            StRun: begin
                if (abort || k_invalid) begin
                    state_d = StIdle;
                    k_d     = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (k_q == LastK) begin
                        state_d = StEn;
                        k_d     = '0;
                    end else begin
                        k_d   = k_q + KW'(1);
                        cnt_d = dwell_q - DWELL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            StEn: begin
                state_d = abort ? StIdle : StValid;
            end
            StValid: begin
                if (!abort && loop_req) begin
                    state_d = StRun;
                    k_d     = KW'(1);
                    dwell_d = dwell_eff;
                    cnt_d   = dwell_eff - DWELL_W'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                k_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they depend on flops only
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            phase   <= NUM_PHASES'(1);
            en      <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            if (state_d == StIdle) begin
                phase <= NUM_PHASES'(1);
            end else if (state_d == StRun) begin
                phase <= NUM_PHASES'(1) << k_d;
            end else begin
                phase <= '0;
            end
            en    <= (state_d == StEn);
            valid <= (state_d == StValid);
            busy  <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: 4- and 6-phase instances checked against a cycle-count timeline model.
module tb_seq_controller;

    logic       clock;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] dwell;
`ifdef SEQ_CONTROLLER_LOOP_EN
    logic       loop_v = 1'b0;
`endif
    logic [3:0] ph4;
    logic [5:0] ph6;
    logic       en4, valid4, busy4, en6, valid6, busy6;

    int n_vec = 0;
    int n_err = 0;

    seq_controller #(.NUM_PHASES(4), .DWELL_W(4)) u_dut4 (
        .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef SEQ_CONTROLLER_LOOP_EN
        .loop(loop_v),
`endif
        .dwell(dwell), .phase(ph4), .en(en4), .valid(valid4), .busy(busy4)
    );

    seq_controller #(.NUM_PHASES(6), .DWELL_W(4)) u_dut6 (
        .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef SEQ_CONTROLLER_LOOP_EN
        .loop(loop_v),
`endif
        .dwell(dwell), .phase(ph6), .en(en6), .valid(valid6), .busy(busy6)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: a running sequence is just "cycle c since start" with dwell D
    bit m_act [2];
    int m_c   [2];
    int m_d   [2];

    function automatic int np(int i);
        return (i == 0) ? 4 : 6;
    endfunction

    function automatic logic [18:0] model_out(int i);
        int last;
        logic [15:0] p;
        if (!m_act[i]) return {16'd1, 3'b000};
        last = (np(i) - 1) * m_d[i];
        if (m_c[i] <= last) begin
            p = 16'd1 << (1 + (m_c[i] - 1) / m_d[i]);
            return {p, 3'b001};
        end
        if (m_c[i] == last + 1) return {16'd0, 3'b101};
        return {16'd0, 3'b011};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0;
            m_c[i]   = 0;
        end
    endtask

    task automatic model_edge();
        bit relatch;
        relatch = 0;
`ifdef SEQ_CONTROLLER_LOOP_EN
        relatch = loop_v;
`endif
        for (int i = 0; i < 2; i++) begin
            if (!m_act[i]) begin
                if (start && !abort) begin
                    m_act[i] = 1;
                    m_c[i]   = 1;
                    m_d[i]   = (dwell == 0) ? 1 : int'(dwell);
                end
            end else if (abort) begin
                m_act[i] = 0;
            end else if (m_c[i] == (np(i) - 1) * m_d[i] + 2) begin
                if (relatch) begin
                    m_c[i] = 1;
                    m_d[i] = (dwell == 0) ? 1 : int'(dwell);
                end else begin
                    m_act[i] = 0;
                end
            end else begin
                m_c[i]++;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("model4", {13'd0, 12'd0, ph4, en4, valid4, busy4}, {13'd0, model_out(0)});
        check("model6", {13'd0, 10'd0, ph6, en6, valid6, busy6}, {13'd0, model_out(1)});
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point
    task automatic step(input logic s, input logic a, input logic [3:0] d);
        start = s;
        abort = a;
        dwell = d;
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic       start;
        logic       abort;
        logic [3:0] dwell;
        logic [3:0] ph;
        logic       en;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int e4, e6, c;
        bit seen;

        tbl[0]  = '{1'b1, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 4'd0, 4'b0100, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 4'd0, 4'b1000, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 4'd2, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 4'd2, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'd2, 4'b0100, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 4'd2, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'd2, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 4'd2, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'd2, 4'b0001, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dwell = 4'd0;
        model_reset();
        #12;
        check("reset4", {ph4, en4, valid4, busy4}, {4'b0001, 3'b000});
        check("reset6", {ph6, en6, valid6, busy6}, {6'b000001, 3'b000});
        #4 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].start, tbl[i].abort, tbl[i].dwell);
            check($sformatf("tbl[%0d]", i), {ph4, en4, valid4, busy4},
                  {tbl[i].ph, tbl[i].en, tbl[i].valid, tbl[i].busy});
        end

        // Dwell 3, changed mid-run: en lands at cycle (N-1)*3+1
        e4 = 0;
        e6 = 0;
        step(1'b1, 1'b0, 4'd3);
        for (c = 1; c <= 100; c++) begin
            if (c > 1) step(1'b0, 1'b0, 4'd7);
            if (en4 && e4 == 0) e4 = c;
            if (en6 && e6 == 0) e6 = c;
            if (valid6) break;
        end
        check("en_cycle4", e4, 10);
        check("en_cycle6", e6, 16);
        step(1'b0, 1'b0, 4'd0);

        // start held high: one idle cycle after valid, then a new sequence
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b1, 1'b0, 4'd1);
            seen = valid4;
        end
        check("hold_valid_seen", {31'd0, seen}, 32'd1);
        step(1'b1, 1'b0, 4'd1);
        check("hold_idle", {ph4, busy4}, {4'b0001, 1'b0});
        step(1'b1, 1'b0, 4'd1);
        check("hold_restart", {ph4, busy4}, {4'b0010, 1'b1});
        step(1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 4'd0);

        // Asynchronous reset between edges while in EN
        step(1'b1, 1'b0, 4'd1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 1'b0, 4'd1);
            seen = en4;
        end
        check("en_reached", {31'd0, seen}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst4", {ph4, en4, valid4, busy4}, {4'b0001, 3'b000});
        check("async_rst6", {ph6, en6, valid6, busy6}, {6'b000001, 3'b000});
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 4'd0);
        check("no_valid_after_rst", {31'd0, valid4}, 32'd0);
        step(1'b1, 1'b0, 4'd0);
        check("first_start_after_rst", {ph4, busy4}, {4'b0010, 1'b1});
        step(1'b0, 1'b1, 4'd0);

        // Maximum dwell with no wrap
        step(1'b1, 1'b0, 4'd15);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)));

`ifdef SEQ_CONTROLLER_LOOP_EN
        loop_v = 1'b1;
        step(1'b1, 1'b0, 4'd1);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 4'd1);
            check("loop_busy", {31'd0, busy4}, 32'd1);
        end
        loop_v = 1'b0;
        step(1'b0, 1'b1, 4'd0);
`endif

        for (int i = 0; i < 1500; i++) begin
`ifdef SEQ_CONTROLLER_LOOP_EN
            loop_v = 1'($urandom_range(0, 1));
`endif
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
                 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
